// File: rtl/gray_count_receiver_if.sv
// Bus between a gray-count transmitter and its receiver.
// Latency: n/a (wiring only). Backpressure: none, the receiver samples every cycle.
// Signals: gray_in/clear_err toward the receiver; decoded count, status pulses and error stats back.
interface gray_count_receiver_if #(
   parameter int WIDTH     = 4,
   parameter int ERR_CNT_W = 8
);
   logic [WIDTH-1:0]     gray_in;
   logic                 clear_err;
   logic [WIDTH-1:0]     bin_out;
   logic [WIDTH-1:0]     gray_q;
   logic                 locked;
   logic                 valid;
   logic                 dir_up;
   logic                 wrap;
   logic                 step_err;
   logic [ERR_CNT_W-1:0] err_count;

   // master drives the gray count and observes the receiver status
   modport master (
      output gray_in, clear_err,
      input  bin_out, gray_q, locked, valid, dir_up, wrap, step_err, err_count
   );

   // slave is the receiver itself
   modport slave (
      input  gray_in, clear_err,
      output bin_out, gray_q, locked, valid, dir_up, wrap, step_err, err_count
   );
endinterface

// File: rtl/gray_count_receiver.sv
// Receives a gray-coded count, synchronises and decodes it, classifies steps, keeps error stats.
// Latency: gray_in change -> bin_out/valid after SYNC_STAGES+1 edges; up to one change per cycle.
// Backpressure: none; every change reaching the synchroniser output is accepted.
// Ports: clk, reset (sync, active-high); bus.slave carries gray_in/clear_err in and
//   bin_out, gray_q, locked, valid, dir_up, wrap, step_err, err_count out (all registered).
module gray_count_receiver #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ERR_CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   gray_count_receiver_if.slave  bus
);

   localparam int ACQ_W = $clog2(SYNC_STAGES + 1);

   typedef enum logic {
      ST_ACQUIRE = 1'b0,
      ST_TRACK   = 1'b1
   } state_t;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   state_t               state_q, state_d;
   logic [ACQ_W-1:0]     acq_cnt_q, acq_cnt_d;
   logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]     ref_gray_q, ref_gray_d;
   logic [WIDTH-1:0]     bin_q, bin_d;
   logic                 locked_q, locked_d;
   logic                 valid_q, valid_d;
   logic                 dir_up_q, dir_up_d;
   logic                 wrap_q, wrap_d;
   logic                 step_err_q, step_err_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [WIDTH-1:0]     sync_last;
   logic [WIDTH-1:0]     sync_bin;
   logic [WIDTH-1:0]     diff;
   logic                 multi_bit;
   logic [WIDTH-1:0]     bin_inc;

   assign sync_last = sync_q[SYNC_STAGES-1];
   assign sync_bin  = gray2bin(sync_last);
   assign diff      = sync_last ^ ref_gray_q;
   assign multi_bit = ($countones(diff) > 1);
   assign bin_inc   = bin_q + WIDTH'(1);

   // Synchroniser chain; reset flushes it so a re-lock never sees stale data.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= bus.gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_ACQUIRE;
         acq_cnt_q  <= '0;
         ref_gray_q <= '0;
         bin_q      <= '0;
         locked_q   <= 1'b0;
         valid_q    <= 1'b0;
         dir_up_q   <= 1'b0;
         wrap_q     <= 1'b0;
         step_err_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         acq_cnt_q  <= acq_cnt_d;
         ref_gray_q <= ref_gray_d;
         bin_q      <= bin_d;
         locked_q   <= locked_d;
         valid_q    <= valid_d;
         dir_up_q   <= dir_up_d;
         wrap_q     <= wrap_d;
         step_err_q <= step_err_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      acq_cnt_d  = acq_cnt_q;
      ref_gray_d = ref_gray_q;
      bin_d      = bin_q;
      locked_d   = locked_q;
      valid_d    = 1'b0;
      dir_up_d   = 1'b0;
      wrap_d     = 1'b0;
      step_err_d = step_err_q;
      err_cnt_d  = err_cnt_q;

      // Clear first so an illegal jump in the same cycle overrides it below.
      if (bus.clear_err) begin
         step_err_d = 1'b0;
         err_cnt_d  = '0;
      end

      case (state_q)
         ST_ACQUIRE: begin
            // Wait until the chain holds only post-reset samples, then take the reference silently.
            if (acq_cnt_q == ACQ_W'(SYNC_STAGES)) begin
               ref_gray_d = sync_last;
               bin_d      = sync_bin;
               locked_d   = 1'b1;
               state_d    = ST_TRACK;
            end else begin
               acq_cnt_d = acq_cnt_q + ACQ_W'(1);
            end
         end
         ST_TRACK: begin
            if (diff != '0) begin
               ref_gray_d = sync_last;
               bin_d      = sync_bin;
               valid_d    = 1'b1;
               if (multi_bit) begin
                  // Resync to the new value but record the broken link.
                  step_err_d = 1'b1;
                  if (bus.clear_err) begin
                     err_cnt_d = ERR_CNT_W'(1);
                  end else if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                  end
               end else begin
                  dir_up_d = (sync_bin == bin_inc);
                  wrap_d   = ((bin_q == '1) && (sync_bin == '0)) ||
                             ((bin_q == '0) && (sync_bin == '1));
               end
            end
         end
         default: begin
            state_d = ST_ACQUIRE;
         end
      endcase
   end

   assign bus.bin_out   = bin_q;
   assign bus.gray_q    = ref_gray_q;
   assign bus.locked    = locked_q;
   assign bus.valid     = valid_q;
   assign bus.dir_up    = dir_up_q;
   assign bus.wrap      = wrap_q;
   assign bus.step_err  = step_err_q;
   assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_count_receiver.sv
module tb_gray_count_receiver;

   logic clk = 1'b0;
   logic reset;

   gray_count_receiver_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();

   gray_count_receiver #(.WIDTH(4), .SYNC_STAGES(2), .ERR_CNT_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       valid;
      logic       dir_up;
      logic       wrap;
      logic       step_err;
      logic       locked;
      logic [3:0] bin;
      logic [3:0] gray;
      logic [7:0] errc;
   } obs_t;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: the count as a plain integer plus the link statistics.
   int m_bin, m_gray, m_sterr, m_errc;

   function automatic logic [3:0] to_gray(input int b);
      logic [3:0] x;
      x = b[3:0];
      return x ^ (x >> 1);
   endfunction

   // Decode by search over all counts: whichever binary value encodes to g.
   function automatic int from_gray(input logic [3:0] g);
      int r;
      r = 0;
      for (int b = 0; b < 16; b++) begin
         if (to_gray(b) == g) r = b;
      end
      return r;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.valid    = bus.valid;
      o.dir_up   = bus.dir_up;
      o.wrap     = bus.wrap;
      o.step_err = bus.step_err;
      o.locked   = bus.locked;
      o.bin      = bus.bin_out;
      o.gray     = bus.gray_q;
      o.errc     = bus.err_count;
      return o;
   endfunction

   task automatic model_step(input logic [3:0] g, input bit clr, output obs_t e);
      int nb, hd;
      nb = from_gray(g);
      hd = $countones(g ^ m_gray[3:0]);
      e = '0;
      e.locked = 1'b1;
      if (hd == 0) begin
         if (clr) begin m_sterr = 0; m_errc = 0; end
      end else if (hd == 1) begin
         e.valid  = 1'b1;
         e.dir_up = (nb == (m_bin + 1) % 16);
         e.wrap   = (m_bin == 15 && nb == 0) || (m_bin == 0 && nb == 15);
         if (clr) begin m_sterr = 0; m_errc = 0; end
      end else begin
         e.valid = 1'b1;
         m_sterr = 1;
         if (clr) m_errc = 1;
         else if (m_errc < 255) m_errc = m_errc + 1;
      end
      m_bin  = nb;
      m_gray = g;
      e.bin      = m_bin[3:0];
      e.gray     = m_gray[3:0];
      e.step_err = m_sterr[0];
      e.errc     = m_errc[7:0];
   endtask

   // Change gray_in before edge N, pulse clear_err into the accepting edge N+2,
   // capture after N+2 and look at valid one cycle early and one cycle late.
   task automatic apply_step(input logic [3:0] g, input bit clr,
                             output obs_t o, output logic v_early, output logic v_late);
      @(negedge clk);
      bus.gray_in = g;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      v_early = bus.valid;
      bus.clear_err = clr;
      @(posedge clk);
      @(negedge clk);
      o = sample();
      bus.clear_err = 1'b0;
      @(posedge clk);
      @(negedge clk);
      v_late = bus.valid;
   endtask

   task automatic test_reset();
      obs_t o, e;
      bus.gray_in   = 4'b0000;
      bus.clear_err = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (sample() !== obs_t'('0)) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, want 0", sample());
      end
      reset = 1'b0;
      for (int edge_n = 1; edge_n <= 3; edge_n++) begin
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if (bus.locked !== (edge_n == 3) || bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_lock edge %0d: locked=%b valid=%b, want locked=%b valid=0",
                     edge_n, bus.locked, bus.valid, (edge_n == 3));
         end
      end
      m_bin = 0; m_gray = 0; m_sterr = 0; m_errc = 0;
      e = '0;
      e.locked = 1'b1;
      repeat (4) @(negedge clk);
      o = sample();
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL reset_idle: got %h, want %h", o, e);
      end
   endtask

   // Shared compare body is inlined per test on purpose: each test owns its checks.
   task automatic test_walk_up();
      obs_t o, e;
      logic ve, vl;
      for (int i = 1; i <= 16; i++) begin
         model_step(to_gray(i % 16), 1'b0, e);
         apply_step(to_gray(i % 16), 1'b0, o, ve, vl);
         vectors++;
         if (o !== e || ve !== 1'b0 || vl !== 1'b0) begin
            miscompares++;
            $display("FAIL walk_up step %0d: got %h early=%b late=%b, want %h early=0 late=0",
                     i, o, ve, vl, e);
         end
      end
   endtask

   task automatic test_down_and_jump();
      obs_t o, e;
      logic ve, vl;
      logic [3:0] seq [5];
      seq[0] = 4'b1000; seq[1] = 4'b0000; seq[2] = 4'b0001; seq[3] = 4'b0111; seq[4] = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         model_step(seq[i], 1'b0, e);
         apply_step(seq[i], 1'b0, o, ve, vl);
         vectors++;
         if (o !== e || ve !== 1'b0 || vl !== 1'b0) begin
            miscompares++;
            $display("FAIL down_jump gray %b: got %h early=%b late=%b, want %h",
                     seq[i], o, ve, vl, e);
         end
      end
      vectors++;
      if (bus.bin_out !== 4'd6 || bus.err_count !== 8'd1 || bus.step_err !== 1'b1) begin
         miscompares++;
         $display("FAIL jump_result: bin=%0d errc=%0d se=%b, want bin=6 errc=1 se=1",
                  bus.bin_out, bus.err_count, bus.step_err);
      end
   endtask

   task automatic test_clear_and_saturate();
      obs_t o, e;
      logic ve, vl;
      logic [3:0] g;
      // Clear coinciding with an illegal jump: the error wins.
      model_step(4'b0000, 1'b1, e);
      apply_step(4'b0000, 1'b1, o, ve, vl);
      vectors++;
      if (o !== e || o.errc !== 8'd1 || o.step_err !== 1'b1) begin
         miscompares++;
         $display("FAIL clear_vs_jump: got %h, want %h (errc 1, step_err 1)", o, e);
      end
      // Clear alone, no change.
      model_step(4'b0000, 1'b1, e);
      apply_step(4'b0000, 1'b1, o, ve, vl);
      vectors++;
      if (o !== e || ve !== 1'b0 || vl !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_only: got %h early=%b late=%b, want %h", o, ve, vl, e);
      end
      for (int i = 0; i < 256; i++) begin
         g = 4'($urandom_range(0, 15));
         while ($countones(g ^ m_gray[3:0]) < 2) g = 4'($urandom_range(0, 15));
         model_step(g, 1'b0, e);
         apply_step(g, 1'b0, o, ve, vl);
         vectors++;
         if (o !== e || ve !== 1'b0 || vl !== 1'b0) begin
            miscompares++;
            $display("FAIL saturate jump %0d gray %b: got %h early=%b late=%b, want %h",
                     i, g, o, ve, vl, e);
         end
      end
      vectors++;
      if (bus.err_count !== 8'hFF) begin
         miscompares++;
         $display("FAIL saturate_final: errc=%h, want ff", bus.err_count);
      end
   endtask

   task automatic test_random();
      obs_t o, e;
      logic ve, vl;
      logic [3:0] g;
      bit clr;
      for (int i = 0; i < 60; i++) begin
         // Bias toward legal single-step moves, with occasional jumps and clears.
         case ($urandom_range(0, 3))
            0: g = to_gray((m_bin + 15) % 16);
            1: g = 4'($urandom_range(0, 15));
            default: g = to_gray((m_bin + 1) % 16);
         endcase
         clr = ($urandom_range(0, 7) == 0);
         model_step(g, clr, e);
         apply_step(g, clr, o, ve, vl);
         vectors++;
         if (o !== e || ve !== 1'b0 || vl !== 1'b0) begin
            miscompares++;
            $display("FAIL random %0d gray %b clr %b: got %h early=%b late=%b, want %h",
                     i, g, clr, o, ve, vl, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      int start;
      int n;
      int want;
      start = m_bin;
      n = 8;
      for (int k = 0; k <= n + 3; k++) begin
         @(negedge clk);
         if (k >= 3 && k - 3 < n) begin
            want = (start + k - 2) % 16;
            vectors++;
            if (bus.valid !== 1'b1 || bus.dir_up !== 1'b1 || bus.bin_out !== 4'(want)) begin
               miscompares++;
               $display("FAIL back_to_back k=%0d: valid=%b dir=%b bin=%0d, want 1 1 %0d",
                        k, bus.valid, bus.dir_up, bus.bin_out, want);
            end
         end else begin
            vectors++;
            if (bus.valid !== 1'b0) begin
               miscompares++;
               $display("FAIL back_to_back idle k=%0d: valid=%b, want 0", k, bus.valid);
            end
         end
         if (k < n) bus.gray_in = to_gray((start + k + 1) % 16);
      end
      m_bin  = (start + n) % 16;
      m_gray = to_gray(m_bin);
   endtask

   task automatic test_reset_relock();
      obs_t o, e;
      logic ve, vl;
      model_step(4'b1101, 1'b0, e);
      apply_step(4'b1101, 1'b0, o, ve, vl);
      vectors++;
      if (o !== e || o.bin !== 4'd9) begin
         miscompares++;
         $display("FAIL relock_setup: got %h, want %h", o, e);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (sample() !== obs_t'('0)) begin
         miscompares++;
         $display("FAIL relock_in_reset: got %h, want 0", sample());
      end
      reset = 1'b0;
      for (int edge_n = 1; edge_n <= 3; edge_n++) begin
         @(posedge clk);
         @(negedge clk);
         vectors++;
         if (bus.locked !== (edge_n == 3) || bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL relock edge %0d: locked=%b valid=%b, want locked=%b valid=0",
                     edge_n, bus.locked, bus.valid, (edge_n == 3));
         end
      end
      m_sterr = 0; m_errc = 0;
      e = '0;
      e.locked = 1'b1;
      e.bin    = 4'd9;
      e.gray   = 4'b1101;
      repeat (3) @(negedge clk);
      o = sample();
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL relock_state: got %h, want %h", o, e);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      bus.gray_in   = '0;
      bus.clear_err = 1'b0;
      test_reset();
      test_walk_up();
      test_down_and_jump();
      test_clear_and_saturate();
      test_random();
      test_back_to_back();
      test_reset_relock();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
